output_demultiplexer: RTL
=========================

// Module: output_demultiplexer
// PURPOSE
//  - Routes terminal-originated bytes, such as keyboard keystrokes and ident/status replies, to their sinks.
//  - Sinks are the host UART transmitter and, optionally, a local-echo path into the command handler.
//  - Each byte carries a destination mask. A byte may go to UART only, to local only, to both, or be discarded.
//  - UART branch: FIFO buffer, so keystroke bursts survive a slow baud-rate transmitter.
//  - Local branch: single-entry register slice.
// PARAMETERS
//  FIFO_DEPTH  16  UART-branch FIFO entries; power of two, >= 2
//  DROP_W      8   width of saturating dropped-byte counter
// PORTS
//  clk          in   1                   system clock
//  reset        in   1                   synchronous, active-high
//  in_data      in   8                   byte from source
//  in_dest      in   2                   bit0=UART, bit1=local; sampled with in_valid
//  in_valid     in   1                   source holds byte
//  in_ready     out  1                   byte accepted when in_valid && in_ready
//  uart_data    out  8                   FIFO head byte
//  uart_valid   out  1                   FIFO non-empty
//  uart_ready   in   1                   UART transmitter pops head
//  local_data   out  8                   echo byte to command handler
//  local_valid  out  1                   echo slot full
//  local_ready  in   1                   command handler consumes echo byte
//  uart_level   out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
//  drop_count   out  DROP_W              bytes discarded (dest mask 00), saturating
// BEHAVIOUR
//  - Reset values:
//    - FIFO empty; uart_level=0; uart_valid=0; uart_data=0.
//    - local_valid=0; local_data=0; drop_count=0.
//    - Read/write pointers=0.
//    - Reset mid-transfer discards all buffered bytes with no partial output.
//  - Branch readiness:
//    - uart_ok = (uart_level != FIFO_DEPTH).
//    - A pop in the same cycle does NOT free a slot: full means stall.
//    - local_ok = !local_valid || local_ready.
//    - local_ok is a combinational path local_ready -> in_ready (permitted).
//  - in_ready = (!in_dest[0] || uart_ok) && (!in_dest[1] || local_ok). This is all-or-nothing.
//    - A broadcast byte (11) is accepted only when both branches accept in the same cycle.
//    - No partial delivery; no per-branch "already sent" state.
//  - Accept with in_dest=00: byte consumed (in_ready=1) and discarded.
//    - drop_count increments by 1 and holds at all-ones.
//  - UART FIFO:
//    - First-word fall-through: byte accepted in cycle N appears on uart_data/uart_valid in cycle N+1.
//    - Pop when uart_valid && uart_ready.
//    - Push and pop in the same cycle leave uart_level unchanged.
//    - Pointers wrap modulo FIFO_DEPTH. Order is strictly preserved.
//    - uart_data is stable while uart_valid && !uart_ready.
//  - Local slot:
//    - Load on accept with in_dest[1]; local_valid=1 from cycle N+1.
//    - Clear when local_ready && no new load.
//    - Load and consume in the same cycle: the new byte replaces the old; local_valid stays 1.
//    - local_data is stable while local_valid && !local_ready.
//  - Both outputs obey valid/ready: once asserted, valid holds until taken.
//  - in_dest changing while in_valid=1 and in_ready=0 is legal; readiness re-evaluates each cycle.
// CONFIGURATION
//  - LOCAL_ECHO_EN defined: local branch present as above.
//  - LOCAL_ECHO_EN undefined:
//    - No local slot; local_valid=0 and local_data=0 constant.
//    - in_dest[1] ignored; dest 10 counts as a drop; dest 11 behaves as 01.
//    - in_ready depends on uart_ok only.
// TESTING
//  - Reset, then idle 5 cycles -> uart_valid=0, local_valid=0, uart_level=0, drop_count=0, in_ready=1.
//  - 16 bytes 0x41..0x50 dest=01, uart_ready=0 -> uart_level=16, 17th byte in_ready=0.
//    - Then uart_ready=1 -> bytes drain 0x41..0x50 in order.
//  - FIFO full, in_valid=1 dest=01, uart_ready=1 same cycle -> in_ready=0; level goes 15, then push accepted next cycle.
//  - dest=11 byte 0x1B with local_valid=1, local_ready=0 -> in_ready=0, FIFO unchanged.
//    - Raise local_ready -> byte lands in both branches in the same cycle.
//  - 300 bytes dest=00 -> all accepted, nothing output, drop_count=255 (saturated).
//  - LOCAL_ECHO_EN undefined: dest=10 byte 0x0D -> accepted, drop_count=1, local_valid stays 0.

Source files
------------

// File: rtl/output_demultiplexer.sv
`default_nettype none
// ============================================================================
// output_demultiplexer : routes terminal bytes to a UART FIFO and an optional
// local-echo slot (enable with LOCAL_ECHO_EN).   Revision: 1.0
// ============================================================================
module output_demultiplexer #(
  parameter int FIFO_DEPTH = 16,
  parameter int DROP_W     = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    in_data,
  input  logic [1:0]                    in_dest,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [7:0]                    uart_data,
  output logic                          uart_valid,
  input  logic                          uart_ready,
  output logic [7:0]                    local_data,
  output logic                          local_valid,
  input  logic                          local_ready,
  output logic [$clog2(FIFO_DEPTH):0]   uart_level,
  output logic [DROP_W-1:0]             drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;

  logic uart_ok;
  logic local_ok;
  logic dest_local;
  logic accept;
  logic push;
  logic pop;
  logic drop;

  // A pop in the same cycle never frees a slot for the incoming byte.
  assign uart_ok = (level != LW'(FIFO_DEPTH));

`ifdef LOCAL_ECHO_EN
  logic       local_valid_r;
  logic [7:0] local_data_r;

  assign dest_local  = in_dest[1];
  assign local_ok    = !local_valid_r || local_ready;
  assign local_valid = local_valid_r;
  assign local_data  = local_data_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      local_valid_r <= 1'b0;
      local_data_r  <= 8'h00;
    end else if (accept && dest_local) begin
      local_valid_r <= 1'b1;
      local_data_r  <= in_data;
    end else if (local_ready) begin
      local_valid_r <= 1'b0;
    end
  end
`else
  logic unused_local;

  assign unused_local = &{1'b0, in_dest[1], local_ready};
  assign dest_local   = 1'b0;
  assign local_ok     = 1'b1;
  assign local_valid  = 1'b0;
  assign local_data   = 8'h00;
`endif

  // All-or-nothing: every addressed branch must accept in the same cycle.
  assign in_ready = (!in_dest[0] || uart_ok) && (!dest_local || local_ok);
  assign accept   = in_valid && in_ready;
  assign push     = accept && in_dest[0];
  assign pop      = uart_valid && uart_ready;
  assign drop     = accept && !in_dest[0] && !dest_local;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count <= '0;
    end else if (drop && (drop_count != {DROP_W{1'b1}})) begin
      drop_count <= drop_count + DROP_W'(1);
    end
  end

  assign uart_valid = (level != '0);
  assign uart_data  = uart_valid ? mem[rd_ptr] : 8'h00;
  assign uart_level = level;

endmodule
`default_nettype wire
